// File: rtl/handle_mem_port.sv
// ============================================================================
//  Module   : handle_mem_port
//  Purpose  : Queues translated READ/WRITE ops and issues them over req/ack.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module handle_mem_port #(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [2:0]                   i_op,
  input  logic [ADDR_WIDTH-1:0]        i_address,
  input  logic [ADDR_WIDTH-1:0]        i_data,
  output logic                         o_stall,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [ADDR_WIDTH-1:0]        o_mem_addr,
  output logic [ADDR_WIDTH-1:0]        o_mem_wdata,
  input  logic                         i_mem_ack,
  input  logic [ADDR_WIDTH-1:0]        i_mem_rdata,
  output logic [ADDR_WIDTH-1:0]        o_rdata,
  output logic                         o_rvalid,
  output logic                         o_err,
  output logic                         o_overflow,
  output logic                         o_bad_op,
  output logic [$clog2(DEPTH):0]       o_count
);

  localparam int C_PTR_W = $clog2(DEPTH);
  localparam int C_CNT_W = C_PTR_W + 1;
  // Counter only ever needs to reach TIMEOUT-1.
  localparam int C_TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [C_PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [C_PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [C_CNT_W-1:0]      count_q, count_d;
  logic [C_TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;
  logic                    overflow_q, overflow_d;
  logic                    bad_op_q, bad_op_d;

  logic                    fifo_we_q   [DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_addr_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   fifo_data_q [DEPTH];

  logic is_rw;
  logic full;
  logic push;
  logic pop;

  assign is_rw = (i_op == 3'd1) || (i_op == 3'd2);
  // Fullness is judged on the pre-edge count, so a same-cycle pop never makes room.
  assign full  = (count_q == C_CNT_W'(DEPTH));
  assign push  = is_rw && !full;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    to_cnt_d    = to_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    overflow_d  = is_rw && full;
    bad_op_d    = (i_op >= 3'd3);
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          mem_req_d   = 1'b1;
          mem_we_d    = fifo_we_q[rd_ptr_q];
          mem_addr_d  = fifo_addr_q[rd_ptr_q];
          mem_wdata_d = fifo_data_q[rd_ptr_q];
          to_cnt_d    = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_mem_ack) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
          if (!mem_we_q) begin
            rdata_d  = i_mem_rdata;
            rvalid_d = 1'b1;
          end
        end else if (to_cnt_q == C_TO_W'(TIMEOUT - 1)) begin
          pop       = 1'b1;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + C_TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
    count_d = count_q + C_CNT_W'(push) - C_CNT_W'(pop);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      to_cnt_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      overflow_q  <= 1'b0;
      bad_op_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      to_cnt_q    <= to_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      overflow_q  <= overflow_d;
      bad_op_q    <= bad_op_d;
    end
  end

  // Entry storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge i_clock) begin
    if (push && !i_reset) begin
      fifo_we_q[wr_ptr_q]   <= (i_op == 3'd2);
      fifo_addr_q[wr_ptr_q] <= i_address;
      fifo_data_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_stall     = full;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_rdata     = rdata_q;
  assign o_rvalid    = rvalid_q;
  assign o_err       = err_q;
  assign o_overflow  = overflow_q;
  assign o_bad_op    = bad_op_q;
  assign o_count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_handle_mem_port.sv
// ============================================================================
//  Module   : tb_handle_mem_port
//  Purpose  : Directed self-checking bench for handle_mem_port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_handle_mem_port;

  localparam int AW = 64;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b1;
  logic [2:0]    i_op = 3'd0;
  logic [AW-1:0] i_address = '0;
  logic [AW-1:0] i_data = '0;
  logic          o_stall;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [AW-1:0] o_mem_wdata;
  logic          i_mem_ack = 1'b0;
  logic [AW-1:0] i_mem_rdata = '0;
  logic [AW-1:0] o_rdata;
  logic          o_rvalid;
  logic          o_err;
  logic          o_overflow;
  logic          o_bad_op;
  logic [2:0]    o_count;

  int total = 0;
  int bad   = 0;

  handle_mem_port #(.ADDR_WIDTH(AW), .DEPTH(4), .TIMEOUT(8)) dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_op        (i_op),
    .i_address   (i_address),
    .i_data      (i_data),
    .o_stall     (o_stall),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_rdata     (o_rdata),
    .o_rvalid    (o_rvalid),
    .o_err       (o_err),
    .o_overflow  (o_overflow),
    .o_bad_op    (o_bad_op),
    .o_count     (o_count)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    tick();
    tick();
    chk("rst_req",    AW'(o_mem_req), 64'd0);
    chk("rst_count",  AW'(o_count), 64'd0);
    chk("rst_rdata",  o_rdata, 64'd0);
    chk("rst_stall",  AW'(o_stall), 64'd0);
    chk("rst_pulses", AW'({o_rvalid, o_err, o_overflow, o_bad_op}), 64'd0);
    i_reset = 1'b0;

    // Single READ, ack three cycles after the request
    i_op = 3'd1; i_address = 64'h1000;
    tick();
    i_op = 3'd0;
    chk("t1_cnt1",    AW'(o_count), 64'd1);
    chk("t1_noreq",   AW'(o_mem_req), 64'd0);
    tick();
    chk("t1_req",     AW'(o_mem_req), 64'd1);
    chk("t1_we",      AW'(o_mem_we), 64'd0);
    chk("t1_addr",    o_mem_addr, 64'h1000);
    tick();
    tick();
    chk("t1_hold",    AW'(o_mem_req), 64'd1);
    i_mem_ack = 1'b1; i_mem_rdata = 64'hDEAD;
    tick();
    i_mem_ack = 1'b0;
    chk("t1_rvalid",  AW'(o_rvalid), 64'd1);
    chk("t1_rdata",   o_rdata, 64'hDEAD);
    chk("t1_reqlow",  AW'(o_mem_req), 64'd0);
    chk("t1_cnt0",    AW'(o_count), 64'd0);
    tick();
    chk("t1_rv_once", AW'(o_rvalid), 64'd0);
    chk("t1_rd_hold", o_rdata, 64'hDEAD);

    // WRITE then READ, ack held high (also high while IDLE)
    i_mem_ack = 1'b1; i_mem_rdata = 64'h77;
    i_op = 3'd2; i_address = 64'h20; i_data = 64'h5;
    tick();
    chk("t2_idle_ack", AW'(o_mem_req), 64'd0);
    i_op = 3'd1; i_data = 64'h0;
    tick();
    i_op = 3'd0;
    chk("t2_req_w",   AW'(o_mem_req), 64'd1);
    chk("t2_we1",     AW'(o_mem_we), 64'd1);
    chk("t2_wdata",   o_mem_wdata, 64'h5);
    tick();
    chk("t2_gap",     AW'(o_mem_req), 64'd0);
    chk("t2_no_rv_w", AW'(o_rvalid), 64'd0);
    chk("t2_cnt1",    AW'(o_count), 64'd1);
    tick();
    chk("t2_req_r",   AW'(o_mem_req), 64'd1);
    chk("t2_we0",     AW'(o_mem_we), 64'd0);
    chk("t2_addr",    o_mem_addr, 64'h20);
    tick();
    i_mem_ack = 1'b0;
    chk("t2_rvalid",  AW'(o_rvalid), 64'd1);
    chk("t2_rdata",   o_rdata, 64'h77);
    chk("t2_cnt0",    AW'(o_count), 64'd0);

    // Five WRITEs with no ack: fill, overflow, then timeout
    for (int k = 0; k < 5; k++) begin
      i_op = 3'd2; i_address = 64'h100 + 64'(k); i_data = 64'hA0 + 64'(k);
      tick();
      if (k == 2) chk("t3_stall_n", AW'(o_stall), 64'd0);
      if (k == 3) begin
        chk("t3_stall",  AW'(o_stall), 64'd1);
        chk("t3_ovf_n",  AW'(o_overflow), 64'd0);
      end
    end
    i_op = 3'd0;
    chk("t3_ovf",     AW'(o_overflow), 64'd1);
    chk("t3_cnt4",    AW'(o_count), 64'd4);
    chk("t3_req",     AW'(o_mem_req), 64'd1);
    chk("t3_addr",    o_mem_addr, 64'h100);
    // Request has been high for 4 sampled cycles; 4 more expected
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t4_req_hi", AW'(o_mem_req), 64'd1);
      chk("t4_no_err", AW'(o_err), 64'd0);
    end
    chk("t4_ovf_once", AW'(o_overflow), 64'd0);
    tick();
    chk("t4_req_lo",  AW'(o_mem_req), 64'd0);
    chk("t4_err",     AW'(o_err), 64'd1);
    chk("t4_no_rv",   AW'(o_rvalid), 64'd0);
    chk("t4_cnt3",    AW'(o_count), 64'd3);
    tick();
    chk("t4_err_once", AW'(o_err), 64'd0);
    chk("t4_next_req", AW'(o_mem_req), 64'd1);
    chk("t4_next_adr", o_mem_addr, 64'h101);
    chk("t4_next_dat", o_mem_wdata, 64'hA1);

    // Reset while in WAIT with three entries queued
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("t6_req",     AW'(o_mem_req), 64'd0);
    chk("t6_cnt",     AW'(o_count), 64'd0);
    chk("t6_pulses",  AW'({o_rvalid, o_err, o_overflow, o_bad_op}), 64'd0);
    chk("t6_rdata",   o_rdata, 64'd0);
    i_mem_ack = 1'b1; i_mem_rdata = 64'h99;
    tick();
    tick();
    i_mem_ack = 1'b0;
    chk("t6_ack_req", AW'(o_mem_req), 64'd0);
    chk("t6_ack_rv",  AW'(o_rvalid), 64'd0);
    chk("t6_ack_rd",  o_rdata, 64'd0);

    // Illegal op then NOP
    i_op = 3'd5; i_address = 64'h300;
    tick();
    i_op = 3'd0;
    chk("t5_bad",     AW'(o_bad_op), 64'd1);
    chk("t5_cnt",     AW'(o_count), 64'd0);
    tick();
    chk("t5_bad_nop", AW'(o_bad_op), 64'd0);
    tick();
    chk("t5_noreq",   AW'(o_mem_req), 64'd0);
    chk("t5_cnt_end", AW'(o_count), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
